// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared memory types, memory size and arbiter state encoding
`ifndef MEMSIZE
`define MEMSIZE 16
`endif
package memory_arbiter_pkg;
  typedef logic [7:0] DEFAULT_TYPE;
  typedef enum logic {MEMORY_READ = 1'b0, MEMORY_WRITE = 1'b1} MEMORY_FLAG_TYPE;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} ARBITER_STATE_TYPE;
  localparam int MEM_SIZE = `MEMSIZE;
  function automatic logic addr_ok(DEFAULT_TYPE a);
    return int'(a) < MEM_SIZE;
  endfunction
endpackage

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: fetch/data request ports and memory-side bus of the arbiter
interface memory_arbiter_if;
  import memory_arbiter_pkg::*;
  logic f_req;
  DEFAULT_TYPE f_addr;
  logic f_ack;
  DEFAULT_TYPE f_rdata;
  logic f_err;
  logic d_req;
  logic d_we;
  DEFAULT_TYPE d_addr;
  DEFAULT_TYPE d_wdata;
  logic d_ack;
  DEFAULT_TYPE d_rdata;
  logic d_err;
  MEMORY_FLAG_TYPE ctrl_bus;
  DEFAULT_TYPE addr_bus;
  DEFAULT_TYPE write_bus;
  DEFAULT_TYPE read_bus;
  logic busy;
  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, read_bus,
    input  f_ack, f_rdata, f_err, d_ack, d_rdata, d_err, ctrl_bus, addr_bus, write_bus, busy
  );
  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, read_bus,
    output f_ack, f_rdata, f_err, d_ack, d_rdata, d_err, ctrl_bus, addr_bus, write_bus, busy
  );
endinterface

// File: rtl/arbiter_priority.sv
// arbiter_priority: data-over-fetch priority with a starvation counter that lets fetch through
module arbiter_priority #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic f_req,
  input  logic d_req,
  input  logic grant_en,
  output logic grant_f,
  output logic grant_d
);
  localparam int W = $clog2(STARVE_LIMIT + 1);
  logic [W-1:0] starve_cnt;
  always_comb begin
    grant_d = d_req && !(f_req && starve_cnt == W'(STARVE_LIMIT));
    grant_f = f_req && !grant_d;
  end
  always_ff @(posedge CLOCK) begin
    if (RESET || !f_req) starve_cnt <= '0;
    else if (grant_en) starve_cnt <= grant_f ? '0 : starve_cnt + W'(1);
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: two-port (fetch/data) single-memory arbiter with IDLE/ACCESS/RESP sequencing
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input logic CLOCK,
  input logic RESET,
  memory_arbiter_if.slave bus
);
  ARBITER_STATE_TYPE state, state_nx;
  logic grant_f, grant_d, pick, lat_fetch, lat_we, lat_err;
  DEFAULT_TYPE sel_addr;
  arbiter_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_priority (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .f_req(bus.f_req),
    .d_req(bus.d_req),
    .grant_en(pick),
    .grant_f(grant_f),
    .grant_d(grant_d)
  );
  always_ff @(posedge CLOCK) state <= RESET ? IDLE : state_nx;
  always_comb begin
    pick = state != ACCESS && (bus.f_req || bus.d_req);
    sel_addr = grant_f ? bus.f_addr : bus.d_addr;
    state_nx = state == ACCESS ? RESP : pick ? ACCESS : IDLE;
    bus.busy = state == ACCESS;
    bus.ctrl_bus = (state == ACCESS && lat_we && !lat_err) ? MEMORY_WRITE : MEMORY_READ;
  end
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      lat_fetch <= 1'b0;
      lat_we <= 1'b0;
      lat_err <= 1'b0;
      bus.addr_bus <= '0;
      bus.write_bus <= '0;
      bus.f_ack <= 1'b0;
      bus.d_ack <= 1'b0;
      bus.f_err <= 1'b0;
      bus.d_err <= 1'b0;
      bus.f_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      bus.f_ack <= state == ACCESS && lat_fetch;
      bus.d_ack <= state == ACCESS && !lat_fetch;
      bus.f_err <= state == ACCESS && lat_fetch && lat_err;
      bus.d_err <= state == ACCESS && !lat_fetch && lat_err;
      if (state == ACCESS && lat_fetch) bus.f_rdata <= lat_err ? '0 : bus.read_bus;
      if (state == ACCESS && !lat_fetch) bus.d_rdata <= lat_err ? '0 : bus.read_bus;
      if (pick) begin
        lat_fetch <= grant_f;
        lat_we <= grant_d && bus.d_we;
        lat_err <= !addr_ok(sel_addr);
        bus.addr_bus <= addr_ok(sel_addr) ? sel_addr : '0;
        if (grant_d) bus.write_bus <= bus.d_wdata;
      end
    end
  end
endmodule
